// File: rtl/cop0_info.sv
// Shared COP0 definitions: exception record and exception-register bundle
// types, register addresses (RD_*/SEL_*), bit positions (IDX_*), MTC0 write
// masks and the Status reset value.
package cop0_info;

    typedef struct packed {
        logic [31:0] epc;
        logic [31:0] error_epc;
        logic [31:0] status;
        logic [31:0] ebase;
    } cop0_excreg_t;

    typedef struct packed {
        logic        exception_happen;
        logic [31:0] epc;
        logic        in_bd;
        logic [4:0]  exc_code;
        logic        load_addr;
        logic [31:0] badvaddr;
    } cop0_exc_data_t;

    // Register numbers (MFC0/MTC0 rd field) and selects
    localparam logic [4:0] RD_BADVADDR = 5'd8;
    localparam logic [4:0] RD_COUNT    = 5'd9;
    localparam logic [4:0] RD_COMPARE  = 5'd11;
    localparam logic [4:0] RD_STATUS   = 5'd12;
    localparam logic [4:0] RD_CAUSE    = 5'd13;
    localparam logic [4:0] RD_EPC      = 5'd14;
    localparam logic [4:0] RD_EBASE    = 5'd15;
    localparam logic [4:0] RD_LLADDR   = 5'd17;
    localparam logic [4:0] RD_ERROREPC = 5'd30;

    localparam logic [2:0] SEL_BADVADDR = 3'd0;
    localparam logic [2:0] SEL_COUNT    = 3'd0;
    localparam logic [2:0] SEL_COMPARE  = 3'd0;
    localparam logic [2:0] SEL_STATUS   = 3'd0;
    localparam logic [2:0] SEL_CAUSE    = 3'd0;
    localparam logic [2:0] SEL_EPC      = 3'd0;
    localparam logic [2:0] SEL_EBASE    = 3'd1;
    localparam logic [2:0] SEL_LLADDR   = 3'd0;
    localparam logic [2:0] SEL_ERROREPC = 3'd0;

    // Bit positions inside Status / Cause
    localparam int IDX_IE  = 0;
    localparam int IDX_EXL = 1;
    localparam int IDX_ERL = 2;
    localparam int IDX_TI  = 30;
    localparam int IDX_BD  = 31;

    // Bits an MTC0 may change; all other bits hold their value
    localparam logic [31:0] STATUS_WMASK = 32'hF040_FF17;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0080_0300;
    localparam logic [31:0] EBASE_WMASK  = 32'h3FFF_F000;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0004;

endpackage

// File: rtl/cop0_timer.sv
// Count/Compare timer. Count advances every second cycle (phase bit) and
// raises TI when an increment lands on Compare. Built only when
// COP0_TIMER_EN is defined; otherwise Count, Compare and TI are tied to 0.
module cop0_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

`ifdef COP0_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        phase_q;
    logic        ti_q;
    logic [31:0] count_inc;

    assign count_inc = count_q + 32'd1;

    // Timer state: Count load/increment, Compare load, TI set/clear
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
            phase_q   <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            if (count_we) begin
                count_q <= wdata;
                phase_q <= 1'b0;
            end else begin
                phase_q <= ~phase_q;
                if (phase_q) count_q <= count_inc;
            end
            // Compare write clears TI and wins over a same-cycle match
            if (compare_we) begin
                compare_q <= wdata;
                ti_q      <= 1'b0;
            end else if (!count_we && phase_q && (count_inc == compare_q)) begin
                ti_q <= 1'b1;
            end
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;
`else
    logic unused_timer_inputs;
    assign unused_timer_inputs = &{1'b0, clk, rst_n, count_we, compare_we, wdata};

    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

endmodule

// File: rtl/cop0_regfile.sv
// COP0 register file: MTC0 writes, MFC0 reads, exception capture, ERET
// level clearing, interrupt request. The Count/Compare timer lives in
// cop0_timer and is enabled by the COP0_TIMER_EN macro.
module cop0_regfile
    import cop0_info::*;
#(
    parameter int          CPU_NUM     = 0,
    parameter logic [31:0] EBASE_RESET = 32'h8000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [4:0]     wrd,
    input  logic [2:0]     wsel,
    input  logic [31:0]    wdata,
    input  logic [4:0]     rrd,
    input  logic [2:0]     rsel,
    output logic [31:0]    rdata,
    input  cop0_exc_data_t exc,
    input  logic           eret,
    input  logic [5:0]     hw_int,
    output cop0_excreg_t   excreg,
    output logic           int_req,
    output logic           timer_int
);

    localparam logic [9:0] CPU_BITS = 10'(CPU_NUM);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;      // BD, IV, IP[9:8], ExcCode only
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] error_epc_q;
    logic [31:0] ebase_q;
    logic [5:0]  hw_ip_q;               // Cause.IP[7:2]

    logic [31:0] count, compare, cause_rd;
    logic        ti;

    logic wr_status, wr_cause, wr_epc, wr_error_epc, wr_ebase, wr_count, wr_compare;

    assign wr_status    = we && wrd == RD_STATUS   && wsel == SEL_STATUS;
    assign wr_cause     = we && wrd == RD_CAUSE    && wsel == SEL_CAUSE;
    assign wr_epc       = we && wrd == RD_EPC      && wsel == SEL_EPC;
    assign wr_error_epc = we && wrd == RD_ERROREPC && wsel == SEL_ERROREPC;
    assign wr_ebase     = we && wrd == RD_EBASE    && wsel == SEL_EBASE;
    assign wr_count     = we && wrd == RD_COUNT    && wsel == SEL_COUNT;
    assign wr_compare   = we && wrd == RD_COMPARE  && wsel == SEL_COMPARE;

    cop0_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // Next-state for Status/Cause/EPC/BadVAddr; later statements win, giving
    // exception > ERET > MTC0 per field
    // NOTE: every target gets its hold value first, so no path leaves a latch.
    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        if (wr_status) status_d = (status_q & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
        if (wr_cause)  cause_d  = (cause_q & ~CAUSE_WMASK) | (wdata & CAUSE_WMASK);
        if (wr_epc)    epc_d    = wdata;

        if (eret) begin
            if (status_q[IDX_ERL]) status_d[IDX_ERL] = 1'b0;
            else                   status_d[IDX_EXL] = 1'b0;
        end

        if (exc.exception_happen) begin
            if (!status_q[IDX_EXL]) begin
                epc_d          = exc.epc;
                cause_d[IDX_BD] = exc.in_bd;
            end
            status_d[IDX_EXL] = 1'b1;
            cause_d[6:2]      = exc.exc_code;
            if (exc.load_addr) badvaddr_d = exc.badvaddr;
        end
    end

    // Architectural register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q    <= STATUS_RESET;
            cause_q     <= '0;
            epc_q       <= '0;
            badvaddr_q  <= '0;
            error_epc_q <= '0;
            ebase_q     <= {EBASE_RESET[31:10], CPU_BITS};
            hw_ip_q     <= '0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            if (wr_error_epc) error_epc_q <= wdata;
            if (wr_ebase)     ebase_q     <= (ebase_q & ~EBASE_WMASK) | (wdata & EBASE_WMASK);
            hw_ip_q <= {hw_int[5] | ti, hw_int[4:0]};
        end
    end

    // Cause as software sees it: stored fields plus TI and hardware IP bits
    assign cause_rd = cause_q | {1'b0, ti, 14'b0, hw_ip_q, 10'b0};

    // MFC0 read mux; unmapped addresses return 0
    always_comb begin
        rdata = '0;
        case ({rrd, rsel})
            {RD_BADVADDR, SEL_BADVADDR}: rdata = badvaddr_q;
            {RD_COUNT,    SEL_COUNT}:    rdata = count;
            {RD_COMPARE,  SEL_COMPARE}:  rdata = compare;
            {RD_STATUS,   SEL_STATUS}:   rdata = status_q;
            {RD_CAUSE,    SEL_CAUSE}:    rdata = cause_rd;
            {RD_EPC,      SEL_EPC}:      rdata = epc_q;
            {RD_EBASE,    SEL_EBASE}:    rdata = ebase_q;
            {RD_LLADDR,   SEL_LLADDR}:   rdata = '0;
            {RD_ERROREPC, SEL_ERROREPC}: rdata = error_epc_q;
            default:                     rdata = '0;
        endcase
    end

    assign excreg.epc       = epc_q;
    assign excreg.error_epc = error_epc_q;
    assign excreg.status    = status_q;
    assign excreg.ebase     = ebase_q;

    assign int_req = status_q[IDX_IE] & ~status_q[IDX_EXL] & ~status_q[IDX_ERL]
                   & (|(cause_rd[15:8] & status_q[15:8]));
    assign timer_int = ti;

endmodule

// File: tb/tb_cop0_regfile.sv
// Directed-vector bench for cop0_regfile. Timer checks follow COP0_TIMER_EN.
module tb_cop0_regfile;
    import cop0_info::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           we;
    logic [4:0]     wrd;
    logic [2:0]     wsel;
    logic [31:0]    wdata;
    logic [4:0]     rrd;
    logic [2:0]     rsel;
    logic [31:0]    rdata;
    cop0_exc_data_t exc;
    logic           eret;
    logic [5:0]     hw_int;
    cop0_excreg_t   excreg;
    logic           int_req;
    logic           timer_int;

    int n_cmp = 0;
    int n_bad = 0;

    cop0_regfile #(.CPU_NUM(0), .EBASE_RESET(32'h8000_0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .wrd       (wrd),
        .wsel      (wsel),
        .wdata     (wdata),
        .rrd       (rrd),
        .rsel      (rsel),
        .rdata     (rdata),
        .exc       (exc),
        .eret      (eret),
        .hw_int    (hw_int),
        .excreg    (excreg),
        .int_req   (int_req),
        .timer_int (timer_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] rd, input logic [2:0] sel, input logic [31:0] d);
        we = 1'b1; wrd = rd; wsel = sel; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] rd, input logic [2:0] sel,
                            input logic [31:0] exp);
        rrd = rd; rsel = sel;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; we = 1'b0; wrd = '0; wsel = '0; wdata = '0;
        rrd = '0; rsel = '0; exc = '0; eret = 1'b0; hw_int = '0;
        #3;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic raise_exc(input logic [31:0] epc, input logic in_bd, input logic [4:0] code,
                             input logic load_addr, input logic [31:0] bva, input logic with_eret);
        exc.exception_happen = 1'b1;
        exc.epc = epc; exc.in_bd = in_bd; exc.exc_code = code;
        exc.load_addr = load_addr; exc.badvaddr = bva;
        eret = with_eret;
        tick();
        exc = '0;
        eret = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        rd_check("rst_status", RD_STATUS, SEL_STATUS, 32'h0040_0004);
        rd_check("rst_ebase", RD_EBASE, SEL_EBASE, 32'h8000_0000);
        rd_check("rst_cause", RD_CAUSE, SEL_CAUSE, 32'h0);
        check("rst_int_req", {31'b0, int_req}, 32'd0);
        check("rst_timer_int", {31'b0, timer_int}, 32'd0);
        check("rst_excreg_status", excreg.status, 32'h0040_0004);

        // Write masks and no same-cycle bypass
        we = 1'b1; wrd = RD_STATUS; wsel = SEL_STATUS; wdata = 32'hFFFF_FFFF;
        rd_check("status_no_bypass", RD_STATUS, SEL_STATUS, 32'h0040_0004);
        tick();
        we = 1'b0;
        rd_check("status_mask", RD_STATUS, SEL_STATUS, 32'hF040_FF17);
        mtc0(RD_BADVADDR, SEL_BADVADDR, 32'h0000_1234);
        rd_check("badvaddr_ro", RD_BADVADDR, SEL_BADVADDR, 32'h0);
        mtc0(RD_CAUSE, SEL_CAUSE, 32'hFFFF_FFFF);
        rd_check("cause_mask", RD_CAUSE, SEL_CAUSE, 32'h0080_0300);
        mtc0(RD_EBASE, SEL_EBASE, 32'hFFFF_FFFF);
        rd_check("ebase_mask", RD_EBASE, SEL_EBASE, 32'hBFFF_F000);
        check("excreg_ebase", excreg.ebase, 32'hBFFF_F000);
        mtc0(RD_ERROREPC, SEL_ERROREPC, 32'h1234_5678);
        check("excreg_error_epc", excreg.error_epc, 32'h1234_5678);
        rd_check("unmapped_read", 5'd5, 3'd0, 32'h0);

        // ERET level clearing
        do_reset();
        eret = 1'b1; tick(); eret = 1'b0;
        rd_check("eret_clears_erl", RD_STATUS, SEL_STATUS, 32'h0040_0000);
        mtc0(RD_STATUS, SEL_STATUS, 32'h0000_0002);
        eret = 1'b1; tick(); eret = 1'b0;
        rd_check("eret_clears_exl", RD_STATUS, SEL_STATUS, 32'h0000_0000);

        // Exception capture with EXL=0, then with EXL=1
        raise_exc(32'hBFC0_0100, 1'b1, 5'h04, 1'b1, 32'h0000_0003, 1'b0);
        rd_check("exc1_epc", RD_EPC, SEL_EPC, 32'hBFC0_0100);
        check("exc1_excreg_epc", excreg.epc, 32'hBFC0_0100);
        rd_check("exc1_cause", RD_CAUSE, SEL_CAUSE, 32'h8000_0010);
        rd_check("exc1_badvaddr", RD_BADVADDR, SEL_BADVADDR, 32'h0000_0003);
        rd_check("exc1_status", RD_STATUS, SEL_STATUS, 32'h0000_0002);
        raise_exc(32'h0, 1'b0, 5'h05, 1'b0, 32'hDEAD_BEEF, 1'b0);
        rd_check("exc2_epc_hold", RD_EPC, SEL_EPC, 32'hBFC0_0100);
        rd_check("exc2_cause", RD_CAUSE, SEL_CAUSE, 32'h8000_0014);
        rd_check("exc2_badvaddr_hold", RD_BADVADDR, SEL_BADVADDR, 32'h0000_0003);
        eret = 1'b1; tick(); eret = 1'b0;
        rd_check("eret_after_exc", RD_STATUS, SEL_STATUS, 32'h0000_0000);
        raise_exc(32'h0000_0100, 1'b0, 5'h0C, 1'b0, 32'h0, 1'b1);
        rd_check("exc_beats_eret", RD_STATUS, SEL_STATUS, 32'h0000_0002);
        check("exc_eret_epc", excreg.epc, 32'h0000_0100);

        // Hardware interrupt
        do_reset();
        mtc0(RD_STATUS, SEL_STATUS, 32'h0000_0401);
        hw_int = 6'b000001;
        tick();
        rd_check("hw_ip2", RD_CAUSE, SEL_CAUSE, 32'h0000_0400);
        check("hw_int_req", {31'b0, int_req}, 32'd1);
        mtc0(RD_STATUS, SEL_STATUS, 32'h0000_0403);
        check("hw_int_req_exl", {31'b0, int_req}, 32'd0);
        hw_int = 6'b000000;

        // Count/Compare timer
        do_reset();
`ifdef COP0_TIMER_EN
        mtc0(RD_STATUS, SEL_STATUS, 32'h0000_8001);
        mtc0(RD_COMPARE, SEL_COMPARE, 32'd10);
        mtc0(RD_COUNT, SEL_COUNT, 32'd0);
        for (int i = 0; i < 19; i++) tick();
        check("ti_before_match", {31'b0, timer_int}, 32'd0);
        tick();
        check("ti_at_match", {31'b0, timer_int}, 32'd1);
        rd_check("count_at_match", RD_COUNT, SEL_COUNT, 32'd10);
        tick();
        check("timer_int_req", {31'b0, int_req}, 32'd1);
        mtc0(RD_COMPARE, SEL_COMPARE, 32'd100);
        check("ti_cleared", {31'b0, timer_int}, 32'd0);
        mtc0(RD_COUNT, SEL_COUNT, 32'hFFFF_FFFF);
        tick();
        rd_check("count_pre_wrap", RD_COUNT, SEL_COUNT, 32'hFFFF_FFFF);
        tick();
        rd_check("count_wrap", RD_COUNT, SEL_COUNT, 32'h0);
`else
        mtc0(RD_COUNT, SEL_COUNT, 32'd5);
        rd_check("count_disabled", RD_COUNT, SEL_COUNT, 32'h0);
        mtc0(RD_COMPARE, SEL_COMPARE, 32'd3);
        rd_check("compare_disabled", RD_COMPARE, SEL_COMPARE, 32'h0);
        for (int i = 0; i < 30; i++) tick();
        check("ti_disabled", {31'b0, timer_int}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
